// File: rtl/axis_packet_fifo.sv
// AXI-Stream FIFO with cut-through or store-and-forward packet mode.
// Packets longer than the storage are rewound and drained instead of stalling.
module axis_packet_fifo #(
  parameter int AXIS_BYTES        = 1,
  parameter int AXIS_USER_BITS    = 1,
  parameter int LOG2_DEPTH        = 8,
  parameter int PACKET_MODE       = 1,
  parameter int ALMOST_FULL_LEVEL = 2**LOG2_DEPTH - 2
) (
  input  logic                      clk,
  input  logic                      sresetn,
  input  logic                      axis_i_tvalid,
  output logic                      axis_i_tready,
  input  logic [8*AXIS_BYTES-1:0]   axis_i_tdata,
  input  logic [AXIS_USER_BITS-1:0] axis_i_tuser,
  input  logic                      axis_i_tlast,
  output logic                      axis_o_tvalid,
  input  logic                      axis_o_tready,
  output logic [8*AXIS_BYTES-1:0]   axis_o_tdata,
  output logic [AXIS_USER_BITS-1:0] axis_o_tuser,
  output logic                      axis_o_tlast,
  output logic [LOG2_DEPTH:0]       fill_level_o,
  output logic                      almost_full_o,
  output logic                      drop_o
);

  localparam int DEPTH = 2**LOG2_DEPTH;
  localparam int PW    = LOG2_DEPTH + 1;
  localparam int DW    = 8*AXIS_BYTES;
  localparam int EW    = 1 + DW + AXIS_USER_BITS;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
  localparam logic [PW-1:0] LAST_P  = PW'(DEPTH - 1);
  localparam logic [PW-1:0] AF_P    = PW'(ALMOST_FULL_LEVEL);

  typedef enum logic {WRITE, DROP} state_t;

  state_t        state;
  logic [PW-1:0] wr_ptr, commit_ptr, rd_ptr;
  logic [PW-1:0] wr_nxt, commit_nxt, rd_nxt, fill_nxt;
  logic [EW-1:0] mem [DEPTH];
  logic          full, accept, oversize, wr_en, rd_en;

  assign full          = (wr_ptr - rd_ptr) == DEPTH_P;
  assign axis_i_tready = (state == DROP) || !full;
  assign accept        = axis_i_tvalid && axis_i_tready;

  // A non-last beat arriving when the open packet already fills all but
  // one slot can never be committed, so the packet is abandoned.
  assign oversize = (PACKET_MODE != 0) && (state == WRITE) && accept &&
                    !axis_i_tlast && ((wr_ptr - commit_ptr) == LAST_P);
  assign wr_en    = (state == WRITE) && accept && !oversize;
  assign rd_en    = (commit_ptr != rd_ptr) &&
                    (!axis_o_tvalid || axis_o_tready);

  always_comb begin
    wr_nxt = wr_ptr;
    if (oversize)
      wr_nxt = commit_ptr;
    else if (wr_en)
      wr_nxt = wr_ptr + PW'(1);
  end

  always_comb begin
    commit_nxt = commit_ptr;
    if (PACKET_MODE == 0)
      commit_nxt = wr_nxt;
    else if (wr_en && axis_i_tlast)
      commit_nxt = wr_ptr + PW'(1);
  end

  assign rd_nxt   = rd_en ? rd_ptr + PW'(1) : rd_ptr;
  assign fill_nxt = wr_nxt - rd_nxt;

  always_ff @(posedge clk or negedge sresetn) begin
    if (!sresetn) begin
      state         <= WRITE;
      wr_ptr        <= '0;
      commit_ptr    <= '0;
      rd_ptr        <= '0;
      fill_level_o  <= '0;
      almost_full_o <= 1'b0;
      drop_o        <= 1'b0;
      axis_o_tvalid <= 1'b0;
      axis_o_tdata  <= '0;
      axis_o_tuser  <= '0;
      axis_o_tlast  <= 1'b0;
    end else begin
      wr_ptr        <= wr_nxt;
      commit_ptr    <= commit_nxt;
      rd_ptr        <= rd_nxt;
      fill_level_o  <= fill_nxt;
      almost_full_o <= fill_nxt >= AF_P;
      drop_o        <= oversize;
      case (state)
        WRITE:   if (oversize) state <= DROP;
        DROP:    if (accept && axis_i_tlast) state <= WRITE;
        default: state <= WRITE;
      endcase
      if (rd_en) begin
        {axis_o_tlast, axis_o_tdata, axis_o_tuser} <=
          mem[rd_ptr[LOG2_DEPTH-1:0]];
        axis_o_tvalid <= 1'b1;
      end else if (axis_o_tready) begin
        axis_o_tvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr[LOG2_DEPTH-1:0]] <=
        {axis_i_tlast, axis_i_tdata, axis_i_tuser};
  end

endmodule

// File: tb/tb_axis_packet_fifo.sv
// Bench for axis_packet_fifo: three configurations share one input stream,
// each scenario resets and checks the instance it targets.
`timescale 1ns/1ps
module tb_axis_packet_fifo;

  logic clk = 1'b0;
  logic sresetn = 1'b1;
  always #5 clk = ~clk;

  logic       in_valid = 1'b0, in_last = 1'b0, in_user = 1'b0;
  logic [7:0] in_data = 8'h0;
  logic       out_ready = 1'b0;

  logic       a_irdy, a_oval, a_olast, a_ouser, a_af, a_drop;
  logic [7:0] a_odata;
  logic [2:0] a_fill;
  logic       b_irdy, b_oval, b_olast, b_ouser, b_af, b_drop;
  logic [7:0] b_odata;
  logic [2:0] b_fill;
  logic       c_irdy, c_oval, c_olast, c_ouser, c_af, c_drop;
  logic [7:0] c_odata;
  logic [3:0] c_fill;

  int total = 0;
  int passed = 0;

  axis_packet_fifo #(.LOG2_DEPTH(2), .PACKET_MODE(0)) u_a (
    .clk(clk), .sresetn(sresetn),
    .axis_i_tvalid(in_valid), .axis_i_tready(a_irdy),
    .axis_i_tdata(in_data), .axis_i_tuser(in_user),
    .axis_i_tlast(in_last),
    .axis_o_tvalid(a_oval), .axis_o_tready(out_ready),
    .axis_o_tdata(a_odata), .axis_o_tuser(a_ouser),
    .axis_o_tlast(a_olast),
    .fill_level_o(a_fill), .almost_full_o(a_af), .drop_o(a_drop)
  );

  axis_packet_fifo #(.LOG2_DEPTH(2), .PACKET_MODE(1)) u_b (
    .clk(clk), .sresetn(sresetn),
    .axis_i_tvalid(in_valid), .axis_i_tready(b_irdy),
    .axis_i_tdata(in_data), .axis_i_tuser(in_user),
    .axis_i_tlast(in_last),
    .axis_o_tvalid(b_oval), .axis_o_tready(out_ready),
    .axis_o_tdata(b_odata), .axis_o_tuser(b_ouser),
    .axis_o_tlast(b_olast),
    .fill_level_o(b_fill), .almost_full_o(b_af), .drop_o(b_drop)
  );

  axis_packet_fifo #(.LOG2_DEPTH(3), .PACKET_MODE(0),
                     .ALMOST_FULL_LEVEL(6)) u_c (
    .clk(clk), .sresetn(sresetn),
    .axis_i_tvalid(in_valid), .axis_i_tready(c_irdy),
    .axis_i_tdata(in_data), .axis_i_tuser(in_user),
    .axis_i_tlast(in_last),
    .axis_o_tvalid(c_oval), .axis_o_tready(out_ready),
    .axis_o_tdata(c_odata), .axis_o_tuser(c_ouser),
    .axis_o_tlast(c_olast),
    .fill_level_o(c_fill), .almost_full_o(c_af), .drop_o(c_drop)
  );

  task automatic do_reset();
    in_valid = 1'b0; in_last = 1'b0; in_user = 1'b0;
    in_data = 8'h0; out_ready = 1'b0;
    @(negedge clk); sresetn = 1'b0;
    @(negedge clk); sresetn = 1'b1;
  endtask

  task automatic test_reset();
    logic [11:0] flags;
    #3 sresetn = 1'b0;
    #1;
    flags = {a_oval, b_oval, c_oval, a_olast, b_olast, c_olast,
             a_drop, b_drop, c_drop, a_af, b_af, c_af};
    total++;
    if (flags !== 12'h0) $display("FAIL rst_flags: got %h want 000", flags);
    else passed++;
    total++;
    if ({a_fill, b_fill, c_fill} !== 10'h0)
      $display("FAIL rst_fill: got %h want 0", {a_fill, b_fill, c_fill});
    else passed++;
    total++;
    if ({a_odata, b_odata, c_odata, a_ouser, b_ouser, c_ouser} !== 27'h0)
      $display("FAIL rst_data: got %h %h %h want 0", a_odata, b_odata, c_odata);
    else passed++;
    total++;
    if ({a_irdy, b_irdy, c_irdy} !== 3'b111)
      $display("FAIL rst_tready: got %b want 111", {a_irdy, b_irdy, c_irdy});
    else passed++;
    @(negedge clk); sresetn = 1'b1;
  endtask

  task automatic test_cut_through();
    logic [7:0] din [3];
    logic [7:0] exp [$];
    int sent = 0, got = 0, t_in = -1, t_out = -1;
    din = '{8'h11, 8'h22, 8'h33};
    do_reset();
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      out_ready = 1'b1;
      if (a_oval) begin
        if (t_out < 0) t_out = k;
        total++;
        if (exp.size() == 0)
          $display("FAIL ct_extra: got beat %h want none", a_odata);
        else if ({a_olast, a_odata} !== {1'(got == 2), exp[0]})
          $display("FAIL ct_beat%0d: got %b/%h want %b/%h", got,
                   a_olast, a_odata, got == 2, exp[0]);
        else passed++;
        if (exp.size() != 0) void'(exp.pop_front());
        got++;
      end
      in_valid = 1'b0; in_last = 1'b0;
      if (sent < 3) begin
        in_valid = 1'b1; in_data = din[sent]; in_last = (sent == 2);
        if (a_irdy) begin
          exp.push_back(din[sent]);
          if (t_in < 0) t_in = k;
          sent++;
        end
      end
    end
    total++;
    if ((t_out - t_in) !== 2)
      $display("FAIL ct_latency: got %0d want 2", t_out - t_in);
    else passed++;
    total++;
    if (got !== 3) $display("FAIL ct_count: got %0d want 3", got);
    else passed++;
    total++;
    if (a_fill !== 3'd0) $display("FAIL ct_fill: got %0d want 0", a_fill);
    else passed++;
  endtask

  task automatic test_store_forward();
    logic [7:0] din [3];
    logic exp_v;
    din = '{8'h41, 8'h42, 8'h43};
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      exp_v = (k >= 8 && k <= 10);
      total++;
      if (b_oval !== exp_v)
        $display("FAIL sf_valid@%0d: got %b want %b", k, b_oval, exp_v);
      else passed++;
      if (exp_v && b_oval) begin
        total++;
        if ({b_olast, b_odata} !== {1'(k == 10), din[k-8]})
          $display("FAIL sf_beat@%0d: got %b/%h want %b/%h", k,
                   b_olast, b_odata, k == 10, din[k-8]);
        else passed++;
      end
      in_valid = (k == 0 || k == 3 || k == 6);
      in_last = (k == 6);
      if (in_valid) begin
        in_data = din[k/3];
        total++;
        if (b_irdy !== 1'b1) $display("FAIL sf_tready@%0d: got %b want 1", k, b_irdy);
        else passed++;
      end
    end
  endtask

  task automatic test_oversize_drop();
    logic [7:0] exp [$];
    logic [2:0] want_fill;
    int sent = 0, got = 0;
    do_reset();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      want_fill = (k <= 3) ? 3'(k) : 3'd0;
      total++;
      if ({b_drop, b_oval, b_fill} !== {1'(k == 4), 1'b0, want_fill})
        $display("FAIL drop@%0d: got drop=%b val=%b fill=%0d want %b/0/%0d",
                 k, b_drop, b_oval, b_fill, k == 4, want_fill);
      else passed++;
      in_valid = (k < 6); in_last = (k == 5); in_data = 8'hC0 + 8'(k);
      if (k < 6) begin
        total++;
        if (b_irdy !== 1'b1) $display("FAIL drop_tready@%0d: got %b want 1", k, b_irdy);
        else passed++;
      end
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      out_ready = 1'b1;
      if (b_oval) begin
        total++;
        if (exp.size() == 0)
          $display("FAIL after_drop_extra: got %h want none", b_odata);
        else if ({b_olast, b_odata} !== {1'(got == 1), exp[0]})
          $display("FAIL after_drop_beat%0d: got %b/%h want %b/%h", got,
                   b_olast, b_odata, got == 1, exp[0]);
        else passed++;
        if (exp.size() != 0) void'(exp.pop_front());
        got++;
      end
      in_valid = 1'b0; in_last = 1'b0;
      if (sent < 2) begin
        in_valid = 1'b1; in_data = 8'hA1 + 8'(sent); in_last = (sent == 1);
        if (b_irdy) begin exp.push_back(in_data); sent++; end
      end
    end
    total++;
    if (got !== 2) $display("FAIL after_drop_count: got %0d want 2", got);
    else passed++;
  endtask

  task automatic test_exact_depth();
    int got = 0;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      total++;
      if (b_drop !== 1'b0) $display("FAIL exact_drop@%0d: got 1 want 0", k);
      else passed++;
      if (k <= 3) begin
        total++;
        if (b_irdy !== 1'b1) $display("FAIL exact_tready@%0d: got 0 want 1", k);
        else passed++;
      end
      if (k == 4) begin
        total++;
        if ({b_fill, b_irdy} !== {3'd4, 1'b0})
          $display("FAIL exact_full: got fill=%0d rdy=%b want 4/0", b_fill, b_irdy);
        else passed++;
      end
      if (k == 7) begin
        total++;
        if ({b_oval, b_odata} !== {1'b1, 8'hD0})
          $display("FAIL exact_hold: got %b/%h want 1/d0", b_oval, b_odata);
        else passed++;
      end
      in_valid = (k < 4); in_last = (k == 3); in_data = 8'hD0 + 8'(k);
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      out_ready = 1'b1;
      if (b_oval) begin
        total++;
        if ({b_olast, b_odata} !== {1'(got == 3), 8'hD0 + 8'(got)})
          $display("FAIL exact_beat%0d: got %b/%h want %b/%h", got,
                   b_olast, b_odata, got == 3, 8'hD0 + 8'(got));
        else passed++;
        got++;
      end
    end
    total++;
    if (got !== 4) $display("FAIL exact_count: got %0d want 4", got);
    else passed++;
  endtask

  task automatic test_random_stream();
    logic [9:0] exp [$];
    logic [9:0] held = '0;
    logic stall = 1'b0, acc = 1'b0;
    int sent = 0, got = 0;
    do_reset();
    for (int k = 0; k < 20000 && (sent < 1000 || exp.size() != 0); k++) begin
      @(negedge clk);
      if (acc) begin in_valid = 1'b0; acc = 1'b0; end
      out_ready = ($urandom_range(0, 9) < 7);
      total++;
      if (c_af !== (c_fill >= 4'd6))
        $display("FAIL rnd_af@%0d: got %b want %b (fill %0d)", k, c_af, c_fill >= 4'd6, c_fill);
      else passed++;
      total++;
      if (c_fill > 4'd8) $display("FAIL rnd_fill@%0d: got %0d want <=8", k, c_fill);
      else passed++;
      if (stall) begin
        total++;
        if ({c_oval, c_ouser, c_olast, c_odata} !== {1'b1, held})
          $display("FAIL rnd_stable@%0d: got %b/%h want 1/%h", k, c_oval,
                   {c_ouser, c_olast, c_odata}, held);
        else passed++;
      end
      if (c_oval && out_ready) begin
        total++;
        if (exp.size() == 0)
          $display("FAIL rnd_extra@%0d: got %h want none", k, c_odata);
        else if ({c_ouser, c_olast, c_odata} !== exp[0])
          $display("FAIL rnd_beat%0d: got %h want %h", got,
                   {c_ouser, c_olast, c_odata}, exp[0]);
        else passed++;
        if (exp.size() != 0) void'(exp.pop_front());
        got++;
      end
      stall = c_oval && !out_ready;
      held = {c_ouser, c_olast, c_odata};
      if (!in_valid && sent < 1000 && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1; in_data = 8'($urandom);
        in_last = 1'($urandom); in_user = 1'($urandom);
      end
      if (in_valid && c_irdy) begin
        exp.push_back({in_user, in_last, in_data});
        sent++; acc = 1'b1;
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    total++;
    if (got !== 1000 || exp.size() != 0)
      $display("FAIL rnd_total: got %0d beats want 1000 (pending %0d)", got, exp.size());
    else passed++;
    @(negedge clk);
    total++;
    if (c_fill !== 4'd0) $display("FAIL rnd_end_fill: got %0d want 0", c_fill);
    else passed++;
  endtask

  task automatic test_random_packets();
    logic [9:0] exp [$];
    logic keep = 1'b1, acc = 1'b0, done = 1'b0;
    int npk = 0, len = 0, idx = 0, got = 0, drops = 0, drops_exp = 0;
    do_reset();
    for (int k = 0; k < 20000 && !done; k++) begin
      @(negedge clk);
      if (acc) begin in_valid = 1'b0; acc = 1'b0; end
      if (b_drop) drops++;
      out_ready = ($urandom_range(0, 9) < 8);
      if (b_oval && out_ready) begin
        total++;
        if (exp.size() == 0)
          $display("FAIL pk_extra@%0d: got %h want none", k, b_odata);
        else if ({b_ouser, b_olast, b_odata} !== exp[0])
          $display("FAIL pk_beat%0d: got %h want %h", got,
                   {b_ouser, b_olast, b_odata}, exp[0]);
        else passed++;
        if (exp.size() != 0) void'(exp.pop_front());
        got++;
      end
      if (!in_valid && $urandom_range(0, 3) != 0) begin
        if (idx == len && npk < 60) begin
          len = $urandom_range(1, 6); idx = 0; npk++;
          keep = (len <= 4);
          if (!keep) drops_exp++;
        end
        if (idx < len) begin
          in_valid = 1'b1; in_data = 8'($urandom);
          in_user = 1'($urandom); in_last = (idx == len - 1);
          idx++;
        end
      end
      if (in_valid && b_irdy) begin
        acc = 1'b1;
        if (keep) exp.push_back({in_user, in_last, in_data});
      end
      done = (npk == 60) && (idx == len) && !in_valid && (exp.size() == 0);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (b_drop) drops++;
    end
    total++;
    if (!done) $display("FAIL pk_timeout: got pending %0d want 0", exp.size());
    else passed++;
    total++;
    if (drops !== drops_exp)
      $display("FAIL pk_drops: got %0d want %0d", drops, drops_exp);
    else passed++;
    total++;
    if (b_fill !== 3'd0) $display("FAIL pk_end_fill: got %0d want 0", b_fill);
    else passed++;
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [7:0] exp [$];
    int sent = 0, got = 0;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      in_valid = (k < 2); in_last = 1'b0; in_data = 8'hE0 + 8'(k);
    end
    total++;
    if (a_oval !== 1'b1) $display("FAIL ar_pre: got tvalid %b want 1", a_oval);
    else passed++;
    #2 sresetn = 1'b0;
    #1;
    total++;
    if ({a_oval, a_fill, a_odata} !== 12'h0)
      $display("FAIL ar_async: got val=%b fill=%0d data=%h want 0", a_oval, a_fill, a_odata);
    else passed++;
    #1 sresetn = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      out_ready = 1'b1;
      if (a_oval) begin
        total++;
        if (exp.size() == 0)
          $display("FAIL ar_stale: got %h want none", a_odata);
        else if ({a_olast, a_odata} !== {1'(got == 2), exp[0]})
          $display("FAIL ar_beat%0d: got %b/%h want %b/%h", got,
                   a_olast, a_odata, got == 2, exp[0]);
        else passed++;
        if (exp.size() != 0) void'(exp.pop_front());
        got++;
      end
      in_valid = 1'b0; in_last = 1'b0;
      if (sent < 3) begin
        in_valid = 1'b1; in_data = 8'h51 + 8'(sent); in_last = (sent == 2);
        if (a_irdy) begin exp.push_back(in_data); sent++; end
      end
    end
    total++;
    if (got !== 3) $display("FAIL ar_count: got %0d want 3", got);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_cut_through();
    test_store_forward();
    test_oversize_drop();
    test_exact_depth();
    test_random_stream();
    test_random_packets();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
